jtag_tap_master: RTL and testbench
==================================

Name: jtag_tap_master

Overview:
- Host-side JTAG driver: generates TCK/TMS/TDI and samples TDO to walk an IEEE 1149.1 TAP through IR scans, DR scans and TAP resets.
- Provides the initiating end of the scan chain, so virtual-JTAG debug logic can be exercised in simulation or from on-chip logic driving an external JTAG header.
- Takes commands on a valid/ready interface and returns the captured TDO bits on a valid/ready response interface.

Parameters:
- CLK_DIV, 2, clk cycles per TCK half-period; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_type  input  2  0=DR scan, 1=IR scan, 2=TAP reset, 3=reserved (executed as TAP reset)
- cmd_len  input  5  scan length minus 1 (1..32 bits)
- cmd_data  input  32  TDI bits, bit0 shifted first
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed
- rsp_data  output  32  captured TDO bits; bit i is the i-th bit shifted; bits >= length read 0
- tck  output  1  JTAG clock
- tms  output  1  JTAG mode select
- tdi  output  1  JTAG data out
- tdo  input  1  JTAG data in, synchronous to tck

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
- TCK generation:
  - One TCK cycle is tck low for CLK_DIV clks, then high for CLK_DIV clks.
  - tms and tdi change only on the clk where tck goes 1->0.
  - tdo is sampled on the clk where tck goes 0->1.
- State machine: INIT, IDLE, PRE, SHIFT, POST, RESP.
- INIT:
  - Entered after reset release.
  - Sends 5 TCK cycles with TMS=1, then 1 with TMS=0, leaving the TAP in Run-Test/Idle.
  - Then goes to IDLE.
- IDLE:
  - cmd_ready=1, tck held 0, tms=0.
  - Transfer on cmd_valid && cmd_ready; the block latches type, length and data, and drops cmd_ready on the next clk.
- PRE (TMS sequence per TCK cycle):
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0.
  - TAP reset: 1,1,1,1,1 then 0, and goes directly to RESP with rsp_data=0.
- SHIFT:
  - N=cmd_len+1 TCK cycles; tdi = data bit i on cycle i.
  - TMS=0 except the last bit, which has TMS=1 (to Exit1).
  - TDO sampled on each rising edge is stored into bit i.
- POST: TMS 1,0 (Update, Run-Test/Idle).
- RESP:
  - rsp_valid=1, rsp_data stable until the rsp_valid && rsp_ready transfer.
  - Returns to IDLE on the clk after the transfer.
  - cmd_ready stays 0 while a response is pending; a command cannot overlap an unconsumed response.
- Latency: a DR scan of N bits completes in (3+N+2) TCK cycles from acceptance, plus 1 clk to rsp_valid. An IR scan adds 1 TCK cycle.
- Boundary conditions:
  - N=1: the single shift bit carries TMS=1.
  - N=32: full data width, no truncation.
  - Bits above N in rsp_data are 0.
  - cmd_data bits above N are ignored.
- Reset mid-operation: all outputs return to their reset values asynchronously, any partial response is discarded, and INIT reruns after release.
- rsp_ready held high in RESP: the response is consumed in one clk.
- rsp_ready asserted outside RESP: ignored.

Optional Feature:
- Macro JTAG_TAP_MASTER_TRST_EN.
- When defined:
  - Adds output trst_n (1 bit, reset value 0).
  - trst_n stays 0 through INIT's first 5 TCK cycles, then 1.
  - A TAP reset command additionally drives trst_n=0 for the whole PRE sequence.
- When undefined: no trst_n port, and TAP reset is by TMS only.

Test Plan:
- Reset release, CLK_DIV=2 -> first tck rise 2 clks after INIT starts; TMS sequence 1,1,1,1,1,0; then cmd_ready=1 with tck=0.
- DR scan, cmd_len=7, cmd_data=0xA5, tdo looped to tdi through a 1-bit tck-rising flop:
  - TMS sequence 1,0,0,0x7,1,1,0.
  - rsp_data=0x4A plus the flop's initial bit in bit0.
  - All bits above 7 are 0.
- IR scan, cmd_len=1, cmd_data=0x2, tdo tied 1:
  - TMS sequence 1,1,0,0,0,1,1,0.
  - tdi bits 0,1.
  - rsp_data=0x3.
- DR scan, cmd_len=31, cmd_data=0xDEADBEEF against a 32-bit TAP model capturing 0x12345678 -> rsp_data=0x12345678 and model register=0xDEADBEEF.
- Hold rsp_ready=0 for 20 clks after rsp_valid -> rsp_data stable, cmd_ready=0, and a second cmd_valid is not accepted until the response transfer.
- Assert reset_n=0 mid-SHIFT, bit 5 of 16 -> tck=0, tms=1, rsp_valid=0 immediately; INIT repeats after release.

Source files
------------

// File: rtl/jtag_tap_master.sv
// Host-side JTAG TAP driver: walks the TAP through DR scans, IR scans and TAP resets.
// Optional macro JTAG_TAP_MASTER_TRST_EN adds an active-low trst_n output.
module jtag_tap_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
`ifdef JTAG_TAP_MASTER_TRST_EN
    ,
    output logic        trst_n
`endif
);

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RESP} state_t;

    localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  idx;
    logic [1:0]  typ;
    logic [4:0]  len;
    logic [31:0] data;
    logic [5:0]  pre_pat;
    logic [2:0]  pre_last;

    // TMS pattern (bit0 first) and last cycle index of the lead-in for each command type
    always_comb begin
        pre_pat  = 6'b011111;
        pre_last = 3'd5;
        case (typ)
            2'd0: begin pre_pat = 6'b000001; pre_last = 3'd2; end
            2'd1: begin pre_pat = 6'b000011; pre_last = 3'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            cnt       <= '0;
            idx       <= '0;
            typ       <= '0;
            len       <= '0;
            data      <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef JTAG_TAP_MASTER_TRST_EN
            trst_n    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        typ       <= cmd_type;
                        len       <= cmd_len;
                        data      <= cmd_data;
                        cmd_ready <= 1'b0;
                        rsp_data  <= '0;
                        state     <= PRE;
                        idx       <= '0;
                        cnt       <= '0;
                        tms       <= 1'b1;
`ifdef JTAG_TAP_MASTER_TRST_EN
                        if (cmd_type[1]) trst_n <= 1'b0;
`endif
                    end
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= '0;
                        tck <= ~tck;
                        if (!tck) begin
                            if (state == SHIFT) rsp_data[idx] <= tdo;
                        end else begin
                            // falling edge: set up tms/tdi for the next TCK cycle
                            case (state)
                                INIT: begin
                                    if (idx == 5'd5) begin
                                        state     <= IDLE;
                                        idx       <= '0;
                                        tms       <= 1'b0;
                                        cmd_ready <= 1'b1;
                                    end else begin
                                        idx <= idx + 5'd1;
                                        tms <= (idx < 5'd4);
`ifdef JTAG_TAP_MASTER_TRST_EN
                                        if (idx == 5'd4) trst_n <= 1'b1;
`endif
                                    end
                                end
                                PRE: begin
                                    if (idx == {2'b00, pre_last}) begin
                                        idx <= '0;
                                        if (typ[1]) begin
                                            state <= RESP;
                                            tms   <= 1'b0;
`ifdef JTAG_TAP_MASTER_TRST_EN
                                            trst_n <= 1'b1;
`endif
                                        end else begin
                                            state <= SHIFT;
                                            tms   <= (len == 5'd0);
                                            tdi   <= data[0];
                                        end
                                    end else begin
                                        idx <= idx + 5'd1;
                                        tms <= pre_pat[idx[2:0] + 3'd1];
                                    end
                                end
                                SHIFT: begin
                                    if (idx == len) begin
                                        state <= POST;
                                        idx   <= '0;
                                        tms   <= 1'b1;
                                        tdi   <= 1'b0;
                                    end else begin
                                        idx <= idx + 5'd1;
                                        tms <= ((idx + 5'd1) == len);
                                        tdi <= data[idx + 5'd1];
                                    end
                                end
                                POST: begin
                                    tms <= 1'b0;
                                    if (idx == 5'd1) begin
                                        state <= RESP;
                                        idx   <= '0;
                                    end else begin
                                        idx <= 5'd1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master: loopback flop, tied-high TDO and a behavioural TAP model.
module tb_jtag_tap_master;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [4:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, tdo;
`ifdef JTAG_TAP_MASTER_TRST_EN
    logic        trst_n;
`endif

    jtag_tap_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
`ifdef JTAG_TAP_MASTER_TRST_EN
        , .trst_n(trst_n)
`endif
    );

    always #5 clk = ~clk;

    // TDO sources: 0 = tdi looped through a tck-rising flop, 1 = tied high, 2 = TAP model
    int   tdo_mode = 0;
    logic loop_ff = 1'b0;
    logic tap_tdo = 1'b0;
    assign tdo = (tdo_mode == 0) ? loop_ff : (tdo_mode == 1) ? 1'b1 : tap_tdo;

    always @(posedge tck) loop_ff <= tdi;

    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t        tap = RTI;
    logic [31:0] tap_dr = '0;

    always @(posedge tck) begin
        if (tap == CAPDR)     tap_dr <= 32'h1234_5678;
        else if (tap == SHDR) tap_dr <= {tdi, tap_dr[31:1]};
        case (tap)
            TLR:   tap <= tms ? TLR   : RTI;
            RTI:   tap <= tms ? SELDR : RTI;
            SELDR: tap <= tms ? SELIR : CAPDR;
            CAPDR: tap <= tms ? EX1DR : SHDR;
            SHDR:  tap <= tms ? EX1DR : SHDR;
            EX1DR: tap <= tms ? UPDR  : PADR;
            PADR:  tap <= tms ? EX2DR : PADR;
            EX2DR: tap <= tms ? UPDR  : SHDR;
            UPDR:  tap <= tms ? SELDR : RTI;
            SELIR: tap <= tms ? TLR   : CAPIR;
            CAPIR: tap <= tms ? EX1IR : SHIR;
            SHIR:  tap <= tms ? EX1IR : SHIR;
            EX1IR: tap <= tms ? UPIR  : PAIR;
            PAIR:  tap <= tms ? EX2IR : PAIR;
            EX2IR: tap <= tms ? UPIR  : SHIR;
            default: tap <= tms ? SELDR : RTI;
        endcase
    end

    always @(negedge tck) if (tap == SHDR) tap_tdo <= tap_dr[0];

    // Log of tms/tdi seen at every tck rise
    logic [255:0] tms_log = '0;
    logic [255:0] tdi_log = '0;
    int           nrise = 0;

    always @(posedge tck) begin
        if (nrise < 256) begin
            tms_log[nrise] = tms;
            tdi_log[nrise] = tdi;
        end
        nrise = nrise + 1;
    end

    int ntests = 0;
    int nfail  = 0;
    int base   = 0;

    function automatic logic [63:0] seg(input logic [255:0] v, input int b, input int n);
        logic [255:0] s;
        s = v >> b;
        return s[63:0] & ((64'd1 << n) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [4:0] l, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_type = t; cmd_len = l; cmd_data = d;
        while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
        check("cmd_accept", 64'(cmd_ready), 64'd1);
        base = nrise;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 2000);
        check(tag, 64'(lat), 64'(exp_lat));
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_cleared", 64'(rsp_valid), 64'd0);
        check("ready_again", 64'(cmd_ready), 64'd1);
    endtask

    task automatic init_seq(input string tag);
        int n;
        n = 0;
        base = nrise;
        @(negedge clk);
        reset_n = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!tck && n < 50);
        check({tag, "_first_rise"}, 64'(n), 64'd2);
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_tck_idle"}, 64'(tck), 64'd0);
        check({tag, "_tms_idle"}, 64'(tms), 64'd0);
        check({tag, "_rises"}, 64'(nrise - base), 64'd6);
        check({tag, "_tms_seq"}, seg(tms_log, base, 6), 64'h1F);
        check({tag, "_tap_rti"}, 64'(tap), 64'(RTI));
    endtask

    initial begin
        bit hold_ok;
        int n;

        repeat (3) @(negedge clk);
        check("rst_tck", 64'(tck), 64'd0);
        check("rst_tms", 64'(tms), 64'd1);
        check("rst_tdi", 64'(tdi), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);

        init_seq("init");

        // DR scan, 8 bits, loopback; response held back for 20 clks
        tdo_mode = 0;
        send(2'd0, 5'd7, 32'hFFFF_FFA5);
        wait_rsp("dr8_latency", (3 + 8 + 2) * 2 * CLK_DIV + 1);
        check("dr8_rsp", 64'(rsp_data), 64'h4A);
        cmd_valid = 1'b1; cmd_type = 2'd1; cmd_len = 5'd1; cmd_data = 32'h2;
        hold_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_data !== 32'h4A || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || tck !== 1'b0)
                hold_ok = 1'b0;
        end
        check("dr8_hold_stable", 64'(hold_ok), 64'd1);
        cmd_valid = 1'b0;
        consume();
        check("dr8_rises", 64'(nrise - base), 64'd13);
        check("dr8_tms_seq", seg(tms_log, base, 13), 64'hC01);
        check("dr8_tdi", seg(tdi_log, base + 3, 8), 64'hA5);
        check("dr8_tap_rti", 64'(tap), 64'(RTI));

        // IR scan, 2 bits, tdo tied high
        tdo_mode = 1;
        send(2'd1, 5'd1, 32'h2);
        wait_rsp("ir2_latency", (4 + 2 + 2) * 2 * CLK_DIV + 1);
        check("ir2_rsp", 64'(rsp_data), 64'h3);
        consume();
        check("ir2_tms_seq", seg(tms_log, base, 8), 64'h63);
        check("ir2_tdi", seg(tdi_log, base + 4, 2), 64'h2);
        check("ir2_tap_rti", 64'(tap), 64'(RTI));

        // DR scan, 32 bits, against the TAP model
        tdo_mode = 2;
        send(2'd0, 5'd31, 32'hDEAD_BEEF);
        wait_rsp("dr32_latency", (3 + 32 + 2) * 2 * CLK_DIV + 1);
        check("dr32_rsp", 64'(rsp_data), 64'h1234_5678);
        consume();
        check("dr32_model_reg", 64'(tap_dr), 64'hDEAD_BEEF);
        check("dr32_tms_seq", seg(tms_log, base, 37), 64'hC_0000_0001);
        check("dr32_tap_rti", 64'(tap), 64'(RTI));

        // DR scan, 1 bit: the only shift bit carries TMS=1
        tdo_mode = 1;
        send(2'd0, 5'd0, 32'hFFFF_FFFE);
        wait_rsp("dr1_latency", (3 + 1 + 2) * 2 * CLK_DIV + 1);
        check("dr1_rsp", 64'(rsp_data), 64'h1);
        consume();
        check("dr1_tms_seq", seg(tms_log, base, 6), 64'h19);
        check("dr1_tdi", seg(tdi_log, base + 3, 1), 64'h0);

        // Reserved type runs as TAP reset; rsp_ready held high from IDLE onward
        rsp_ready = 1'b1;
        send(2'd3, 5'd5, 32'hFFFF_FFFF);
        wait_rsp("rst_cmd_latency", 6 * 2 * CLK_DIV + 1);
        check("rst_cmd_rsp", 64'(rsp_data), 64'h0);
        @(negedge clk);
        check("rst_cmd_one_clk", 64'(rsp_valid), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        rsp_ready = 1'b0;
        check("rst_cmd_tms_seq", seg(tms_log, base, 6), 64'h1F);
        check("rst_cmd_tap_rti", 64'(tap), 64'(RTI));

        // Reset asserted during shift bit 5 of a 16-bit DR scan
        tdo_mode = 2;
        send(2'd0, 5'd15, 32'h0000_BEEF);
        n = 0;
        while ((nrise - base) < 9 && n < 500) begin @(negedge clk); n++; end
        check("mid_reach_bit5", 64'(nrise - base), 64'd9);
        #2 reset_n = 1'b0;
        #1;
        check("mid_tck", 64'(tck), 64'd0);
        check("mid_tms", 64'(tms), 64'd1);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_cmd_ready", 64'(cmd_ready), 64'd0);
        check("mid_rsp_data", 64'(rsp_data), 64'd0);
        repeat (2) @(negedge clk);
        init_seq("reinit");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
